// File: rtl/ram_access_ctrl.sv
// Round-robin two-master sequencer for an asynchronous 1K x 8 RAM.
// Every RAM pin and the bus drive enable come straight from a flop.
module ram_access_ctrl #(
    parameter int AW       = 10,
    parameter int DW       = 8,
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          ram_ena,
    output logic          ram_read,
    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data,
    output logic          busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD        = 3'd1;
    localparam logic [2:0] S_WR_SETUP  = 3'd2;
    localparam logic [2:0] S_WR_STROBE = 3'd3;
    localparam logic [2:0] S_WR_HOLD   = 3'd4;

    localparam int CMAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
    localparam int CW   = $clog2(CMAX + 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ptr_q, ptr_d;
    logic          gnt_q, gnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ena_q, ena_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic          drv_q, drv_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic          pick_m0;
    logic          new_we;

    // ptr_q holds the last granted master (1 = m1), so m0 wins a tie after reset
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ena_d      = ena_q;
        read_d     = read_q;
        write_d    = write_q;
        drv_d      = drv_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        pick_m0    = m0_req & (~m1_req | ptr_q);
        new_we     = pick_m0 ? m0_we : m1_we;

        unique case (state_q)
            S_IDLE: begin
                if (m0_req | m1_req) begin
                    gnt_d   = ~pick_m0;
                    ptr_d   = ~pick_m0;
                    addr_d  = pick_m0 ? m0_addr : m1_addr;
                    wdata_d = pick_m0 ? m0_wdata : m1_wdata;
                    ena_d   = 1'b1;
                    if (new_we) begin
                        state_d = S_WR_SETUP;
                        drv_d   = 1'b1;
                    end else begin
                        state_d = S_RD;
                        read_d  = 1'b1;
                        cnt_d   = CW'(RD_WAIT);
                    end
                end
            end
            S_RD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    ena_d   = 1'b0;
                    read_d  = 1'b0;
                    if (gnt_q) begin
                        m1_rdata_d = ram_data;
                        m1_ack_d   = 1'b1;
                    end else begin
                        m0_rdata_d = ram_data;
                        m0_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_STROBE;
                write_d = 1'b1;
                cnt_d   = CW'(WR_PULSE - 1);
            end
            S_WR_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = S_WR_HOLD;
                    write_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WR_HOLD: begin
                state_d  = S_IDLE;
                ena_d    = 1'b0;
                drv_d    = 1'b0;
                m0_ack_d = ~gnt_q;
                m1_ack_d = gnt_q;
            end
            default: begin
                state_d = S_IDLE;
                ena_d   = 1'b0;
                read_d  = 1'b0;
                write_d = 1'b0;
                drv_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= 1'b1;
            gnt_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ena_q      <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            drv_q      <= 1'b0;
            busy_q     <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ena_q      <= ena_d;
            read_q     <= read_d;
            write_q    <= write_d;
            drv_q      <= drv_d;
            busy_q     <= busy_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
        end
    end

    assign ram_data  = drv_q ? wdata_q : {DW{1'bz}};
    assign ram_ena   = ena_q;
    assign ram_read  = read_q;
    assign ram_write = write_q;
    assign ram_addr  = addr_q;
    assign busy      = busy_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;

endmodule
